rr_arb_hold: RTL and testbench

//  Parametrised N-way arbiter with registered one-hot grant. Selectable round-robin or fixed-priority

---
 rtl/rr_arb_hold_pkg.sv | 11 +
 rtl/rr_arb_pick.sv | 44 ++++
 rtl/rr_arb_hold.sv | 64 ++++++
 tb/tb_rr_arb_hold.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_hold_pkg.sv
// Shared constants for the hold-capable round-robin / fixed-priority arbiter.
package rr_arb_hold_pkg;

    // Default number of requesters at a switch output port.
    localparam int DEFAULT_N  = 6;

    // Arbitration policy encodings for the MODE parameter.
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

endpackage : rr_arb_hold_pkg

// File: rtl/rr_arb_pick.sv
// Combinational winner selection for rr_arb_hold.
// Round-robin is a double-width priority encode: the upper copy is the raw
// request vector, and the lower copy keeps only the indices above ptr. The
// lowest set bit of the concatenation is therefore the first requester after
// ptr, wrapping back to the raw vector when nothing is above ptr. In
// fixed-priority mode the lower copy is forced empty, so the scan falls
// straight through to the lowest raw index. Only the 2N real bits are
// scanned, so an index >= N can never be produced for non-power-of-2 N.
module rr_arb_pick #(
    parameter int N   = 6,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           mode,        // 1 = fixed priority, ptr ignored
    output logic [N-1:0]   win_onehot,
    output logic [IDW-1:0] win_id,
    output logic           any
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    int             sel;
    int             idx;

    // Masked/unmasked double-width scan for the lowest set request bit.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] & ~mode & (i > int'(ptr));
        end
        dbl = {req, masked};
        sel = 0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl[j]) sel = j;
        end
        idx        = (sel >= N) ? sel - N : sel;
        any        = |req;
        win_id     = IDW'(idx);
        win_onehot = '0;
        win_onehot[win_id] = any;
    end

endmodule : rr_arb_pick

// File: rtl/rr_arb_hold.sv
// N-way arbiter with registered one-hot grant, round-robin or fixed-priority
// policy, and optional grant locking for multi-flit packets.
// Handshake: en is the downstream ready. When en=0 every register holds,
// including a grant whose owner has dropped req; when en=1 the arbiter
// updates once per cycle and the new grant appears one cycle after req.
module rr_arb_hold
    import rr_arb_hold_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int MODE = MODE_RR,
    parameter int HOLD = 1,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,        // asynchronous, active-low
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   grt,
    output logic [IDW-1:0] grt_id,
    output logic           grt_vld
);

    logic [IDW-1:0] ptr;
    logic [N-1:0]   win_onehot;
    logic [IDW-1:0] win_id;
    logic           any;
    logic           hold_hit;

    rr_arb_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .mode       (MODE == MODE_FIXED),
        .win_onehot (win_onehot),
        .win_id     (win_id),
        .any        (any)
    );

    // The current owner keeps the grant while it still requests.
    assign hold_hit = (HOLD != 0) && grt_vld && req[grt_id];

    // Grant and pointer registers; ptr=N-1 after reset gives index 0 first pick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grt     <= '0;
            grt_id  <= '0;
            grt_vld <= 1'b0;
            ptr     <= IDW'(N-1);
        end else if (en && !hold_hit) begin
            if (any) begin
                grt     <= win_onehot;
                grt_id  <= win_id;
                grt_vld <= 1'b1;
                ptr     <= win_id;
            end else begin
                grt     <= '0;
                grt_vld <= 1'b0;
            end
        end
    end

endmodule : rr_arb_hold

// File: tb/tb_rr_arb_hold.sv
// Bench for rr_arb_hold: four parameterisations run side by side against a
// behavioural model (index scan with modulo arithmetic), directed scenarios
// with literal expectations, then randomized traffic with reset pulses.
module tb_rr_arb_hold;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;

    logic [5:0] req_a = '0, req_b = '0, req_c = '0;
    logic [4:0] req_d = '0;

    logic [5:0] grt_a, grt_b, grt_c;
    logic [4:0] grt_d;
    logic [2:0] id_a, id_b, id_c, id_d;
    logic       vld_a, vld_b, vld_c, vld_d;

    int n_checks = 0;
    int n_fail   = 0;

    // model state per instance: a=RR hold, b=RR no hold, c=fixed, d=N5 RR no hold
    int p_n    [4] = '{6, 6, 6, 5};
    int p_mode [4] = '{0, 0, 1, 0};
    int p_hold [4] = '{1, 0, 0, 0};
    int m_id   [4];
    int m_ptr  [4];
    bit m_vld  [4];

    rr_arb_hold #(.N(6), .MODE(0), .HOLD(1)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .en(en),
        .grt(grt_a), .grt_id(id_a), .grt_vld(vld_a));
    rr_arb_hold #(.N(6), .MODE(0), .HOLD(0)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .en(en),
        .grt(grt_b), .grt_id(id_b), .grt_vld(vld_b));
    rr_arb_hold #(.N(6), .MODE(1), .HOLD(0)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .en(en),
        .grt(grt_c), .grt_id(id_c), .grt_vld(vld_c));
    rr_arb_hold #(.N(5), .MODE(0), .HOLD(0)) u_d (
        .clk(clk), .rst(rst), .req(req_d), .en(en),
        .grt(grt_d), .grt_id(id_d), .grt_vld(vld_d));

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] req_of(input int k);
        case (k)
            0: return req_a;
            1: return req_b;
            2: return req_c;
            default: return {1'b0, req_d};
        endcase
    endfunction

    function automatic logic [5:0] grt_of(input int k);
        case (k)
            0: return grt_a;
            1: return grt_b;
            2: return grt_c;
            default: return {1'b0, grt_d};
        endcase
    endfunction

    function automatic logic [2:0] id_of(input int k);
        case (k)
            0: return id_a;
            1: return id_b;
            2: return id_c;
            default: return id_d;
        endcase
    endfunction

    function automatic logic vld_of(input int k);
        case (k)
            0: return vld_a;
            1: return vld_b;
            2: return vld_c;
            default: return vld_d;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_vld[k] = 1'b0;
            m_id[k]  = 0;
            m_ptr[k] = p_n[k] - 1;
        end
    endtask

    // One enabled cycle of the arbitration rules for instance k.
    task automatic model_step(input int k, input logic [5:0] r);
        int w;
        if (!en) return;
        if (p_hold[k] != 0 && m_vld[k] && r[m_id[k]]) return;
        if (r == 0) begin
            m_vld[k] = 1'b0;
            return;
        end
        w = -1;
        if (p_mode[k] == 1) begin
            for (int i = p_n[k] - 1; i >= 0; i--) if (r[i]) w = i;
        end else begin
            for (int s = p_n[k]; s >= 1; s--) begin
                if (r[(m_ptr[k] + s) % p_n[k]]) w = (m_ptr[k] + s) % p_n[k];
            end
        end
        m_vld[k] = 1'b1;
        m_id[k]  = w;
        m_ptr[k] = w;
    endtask

    task automatic check_all();
        logic [5:0] e;
        logic [5:0] g;
        for (int k = 0; k < 4; k++) begin
            e = '0;
            if (m_vld[k]) e[m_id[k]] = 1'b1;
            g = grt_of(k);
            check($sformatf("grt[%0d]", k), 32'(g), 32'(e));
            check($sformatf("vld[%0d]", k), 32'(vld_of(k)), 32'(m_vld[k]));
            check($sformatf("id[%0d]", k), 32'(id_of(k)), 32'(m_id[k]));
            check($sformatf("onehot[%0d]", k), 32'($countones(g) <= 1), 32'd1);
        end
    endtask

    // driver: one clock, model update, then sample 1ns after the edge
    task automatic step();
        logic [5:0] r [4];
        @(posedge clk);
        for (int k = 0; k < 4; k++) r[k] = req_of(k);
        if (rst) for (int k = 0; k < 4; k++) model_step(k, r[k]);
        #1;
        check_all();
    endtask

    // async reset pulse applied away from the clock edge
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        rst = 1'b1;
    endtask

    logic [5:0] rot_exp [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};

    initial begin
        // 1: reset with full request, then first grant goes to index 0
        req_a = 6'h3F;
        en    = 1'b0;
        @(negedge clk);
        do_reset();
        check("t1_rst_grt", 32'(grt_a), 32'h0);
        check("t1_rst_vld", 32'(vld_a), 32'h0);
        en = 1'b1;
        step();
        check("t1_first", 32'(grt_a), 32'h01);

        // 2: round-robin rotation without hold
        req_a = '0;
        do_reset();
        req_b = 6'h3F;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("t2_rot%0d", i), 32'(grt_b), 32'(rot_exp[i]));
        end
        req_b = '0;

        // 3: lock while owner requests, move on when it drops
        do_reset();
        req_a = 6'h05;
        step();
        check("t3_grant0", 32'(grt_a), 32'h01);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_lock", 32'(grt_a), 32'h01);
        end
        req_a = 6'h04;
        step();
        check("t3_drop_grt", 32'(grt_a), 32'h04);
        check("t3_drop_id", 32'(id_a), 32'd2);

        // 4: en=0 freezes the grant even after req drops
        do_reset();
        req_a = 6'h02;
        step();
        check("t4_grant1", 32'(grt_a), 32'h02);
        en    = 1'b0;
        req_a = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_freeze", 32'(grt_a), 32'h02);
        end
        en = 1'b1;
        step();
        check("t4_idle_grt", 32'(grt_a), 32'h0);
        check("t4_idle_vld", 32'(vld_a), 32'h0);

        // 5: fixed priority ignores the pointer
        do_reset();
        req_c = 6'h30;
        step();
        check("t5_hi", 32'(grt_c), 32'h10);
        req_c = 6'h31;
        step();
        check("t5_lo", 32'(grt_c), 32'h01);
        req_c = '0;

        // 6: wrap on non-power-of-2 N
        do_reset();
        req_d = 5'h10;
        step();
        check("t6_top_grt", 32'(grt_d), 32'h10);
        check("t6_top_id", 32'(id_d), 32'd4);
        req_d = 5'h11;
        step();
        check("t6_wrap", 32'(grt_d), 32'h01);
        req_d = '0;

        // randomized traffic, enable gaps and occasional mid-stream resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_a = 6'($urandom_range(0, 63));
            req_b = 6'($urandom_range(0, 63));
            req_c = 6'($urandom_range(0, 63));
            req_d = 5'($urandom_range(0, 31));
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                // bias toward long-held requests to exercise locking
                req_a = req_a | grt_a;
            end
            step();
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_arb_hold
